// File: rtl/pe_array_sched.sv
// pe_array_sched: sequences LOAD/RUN/DRAIN phases of a PE array and drains psums round-robin
// into the global buffer. Define PE_SCHED_TIMEOUT_EN to add a RUN-phase watchdog.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a configuration, cfg_ready high
// S_LOAD  | pe_load high for P*Q cycles
// S_RUN   | pe_start pulse, then wait for every PE completion capture
// S_DRAIN | round-robin grants, P*NUM_PE buffer writes per pass
// S_DONE  | one-cycle done pulse
module pe_array_sched #(
    parameter int NUM_PE = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [4:0]        cfg_P,
    input  logic [2:0]        cfg_Q,
    input  logic [3:0]        cfg_S,
    input  logic [3:0]        cfg_passes,
    output logic [NUM_PE-1:0] pe_load,
    output logic [NUM_PE-1:0] pe_start,
    input  logic [NUM_PE-1:0] pe_complete,
    input  logic [NUM_PE-1:0] drain_req,
    output logic [NUM_PE-1:0] drain_gnt,
    output logic              gb_wr_en,
    input  logic              gb_wr_ready,
    output logic [ADDR_W-1:0] gb_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [3:0]        pass_idx
);
    localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state, state_nx;

    logic [4:0]        p_q;
    logic [2:0]        q_q;
    logic [3:0]        passes_q;
    logic [7:0]        pq, xf_total, ld_cnt, xf_cnt;
    logic [NUM_PE-1:0] cap, gnt_nx;
    logic [PW-1:0]     ptr, ptr_nx, gnt_idx, gnt_idx_nx, ptr_after, base, pick_idx;
    logic              found, accept, xfer, all_cap, last_xfer, wd_fire;

    assign pq        = {3'b0, p_q} * {5'b0, q_q};
    assign xf_total  = {3'b0, p_q} * 8'(NUM_PE);
    assign accept    = (state == S_IDLE) && cfg_valid && cfg_ready;
    assign xfer      = gb_wr_en && gb_wr_ready;
    assign last_xfer = xfer && (xf_cnt == xf_total - 8'd1);
    assign all_cap   = &cap;
    assign ptr_after = (gnt_idx == PW'(NUM_PE - 1)) ? '0 : gnt_idx + PW'(1);
    assign base      = xfer ? ptr_after : ptr;

`ifdef PE_SCHED_TIMEOUT_EN
    logic [3:0]  s_q;
    logic [11:0] wd_cnt, wd_lim;
    logic [15:0] wd_full;

    // limit saturates at the 12-bit counter range for large tiles
    assign wd_full = {6'b0, pq, 2'b00} * {12'b0, s_q} + 16'd16;
    assign wd_lim  = (wd_full > 16'd4095) ? 12'hFFF : wd_full[11:0];
    assign wd_fire = (state == S_RUN) && !all_cap && (wd_cnt == wd_lim - 12'd1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_q    <= '0;
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            wd_cnt <= (state == S_RUN) ? wd_cnt + 12'd1 : 12'd0;
            if (accept) begin
                s_q <= cfg_S;
                err <= 1'b0;
            end else if (wd_fire) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign wd_fire = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (accept)
                         state_nx = (cfg_P == '0 || cfg_Q == '0 || cfg_S == '0 || cfg_passes == '0)
                                    ? S_DONE : S_LOAD;
            S_LOAD:  if (ld_cnt == pq - 8'd1) state_nx = S_RUN;
            S_RUN:   if (all_cap) state_nx = S_DRAIN;
                     else if (wd_fire) state_nx = S_DONE;
            S_DRAIN: if (last_xfer)
                         state_nx = (pass_idx == passes_q - 4'd1) ? S_DONE : S_LOAD;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // first requester at or after base, wrapping
    always_comb begin
        int idx;
        idx      = 0;
        found    = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            idx = int'(base) + k;
            if (idx >= NUM_PE) idx = idx - NUM_PE;
            if (!found && drain_req[PW'(idx)]) begin
                found    = 1'b1;
                pick_idx = PW'(idx);
            end
        end
    end

    // a stalled grant is held; the final transfer of a pass never launches a new grant
    always_comb begin
        gnt_nx     = '0;
        gnt_idx_nx = gnt_idx;
        ptr_nx     = ptr;
        if (state == S_DRAIN) begin
            if (xfer) ptr_nx = ptr_after;
            if (gb_wr_en && !gb_wr_ready) begin
                gnt_nx = drain_gnt;
            end else if (found && !last_xfer) begin
                gnt_nx     = NUM_PE'(1) << pick_idx;
                gnt_idx_nx = pick_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            p_q       <= '0;
            q_q       <= '0;
            passes_q  <= '0;
            ld_cnt    <= '0;
            xf_cnt    <= '0;
            cap       <= '0;
            ptr       <= '0;
            gnt_idx   <= '0;
            cfg_ready <= 1'b0;
            pe_load   <= '0;
            pe_start  <= '0;
            drain_gnt <= '0;
            gb_wr_en  <= 1'b0;
            gb_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass_idx  <= '0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            gnt_idx   <= gnt_idx_nx;
            drain_gnt <= gnt_nx;
            gb_wr_en  <= |gnt_nx;
            cfg_ready <= (state_nx == S_IDLE);
            pe_load   <= {NUM_PE{state_nx == S_LOAD}};
            pe_start  <= {NUM_PE{(state_nx == S_RUN) && (state != S_RUN)}};
            busy      <= (state_nx != S_IDLE);
            done      <= (state_nx == S_DONE);
            ld_cnt    <= (state == S_LOAD) ? ld_cnt + 8'd1 : 8'd0;
            if (state != S_DRAIN) xf_cnt <= '0;
            else if (xfer)        xf_cnt <= xf_cnt + 8'd1;
            if ((state_nx == S_LOAD) && (state != S_LOAD)) cap <= '0;
            else if (state == S_RUN)                        cap <= cap | pe_complete;
            if (accept) begin
                p_q      <= cfg_P;
                q_q      <= cfg_Q;
                passes_q <= cfg_passes;
                pass_idx <= '0;
                gb_addr  <= '0;
            end else begin
                if (xfer) gb_addr <= gb_addr + ADDR_W'(1);
                if (last_xfer && (state_nx == S_LOAD)) pass_idx <= pass_idx + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_pe_array_sched.sv
// tb_pe_array_sched: randomized self-checking bench for pe_array_sched against a
// transaction-level model (pass counts, grant order, write addresses, phase latencies).
module tb_pe_array_sched;
    localparam int NPE = 4;
    localparam int AW  = 10;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [4:0]     cfg_P = '0;
    logic [2:0]     cfg_Q = '0;
    logic [3:0]     cfg_S = '0;
    logic [3:0]     cfg_passes = '0;
    logic [NPE-1:0] pe_load, pe_start, drain_gnt;
    logic [NPE-1:0] pe_complete = '0;
    logic [NPE-1:0] drain_req = '0;
    logic           gb_wr_en;
    logic           gb_wr_ready = 1'b0;
    logic [AW-1:0]  gb_addr;
    logic           busy, done, err;
    logic [3:0]     pass_idx;

    always #5 clk = ~clk;

    pe_array_sched #(.NUM_PE(NPE), .ADDR_W(AW)) dut (
        .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_P(cfg_P), .cfg_Q(cfg_Q), .cfg_S(cfg_S), .cfg_passes(cfg_passes),
        .pe_load(pe_load), .pe_start(pe_start), .pe_complete(pe_complete),
        .drain_req(drain_req), .drain_gnt(drain_gnt), .gb_wr_en(gb_wr_en),
        .gb_wr_ready(gb_wr_ready), .gb_addr(gb_addr), .busy(busy), .done(done),
        .err(err), .pass_idx(pass_idx)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int m_ptr    = 0;
    int fixed_lat = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int next_pe(input logic [3:0] m, input int ptr);
        for (int k = 0; k < NPE; k++)
            if (m[(ptr + k) % NPE]) return (ptr + k) % NPE;
        return -1;
    endfunction

    function automatic logic [31:0] all_outs();
        return {1'b0, cfg_ready, pe_load, pe_start, drain_gnt, gb_wr_en, gb_addr, busy, done, err, pass_idx};
    endfunction

    task automatic do_reset();
        rstn        = 1'b0;
        cfg_valid   = 1'b0;
        pe_complete = '0;
        #1;
        check("outs_zero_in_reset", all_outs(), 0);
        repeat (2) @(negedge clk);
        rstn  = 1'b1;
        m_ptr = 0;
        @(negedge clk);
        check("cfg_ready_after_release", cfg_ready, 1);
    endtask

    task automatic run_cfg(input int p, input int q, input int s, input int np,
                           input logic [3:0] mask, input int rmode, input bit pulse,
                           input bit kill3, input int rst_at);
        bit zero, fin, rdy, first_wr_seen, prev_wr, prev_xfer, last_prev, timed_out;
        int pq, pass, xf_pass, xf_total, ld_cycles, starts, dones, t, start_t;
        int first_xf_t, lat_max, stall2, m_addr, e;
        logic [3:0] prev_gnt;
        bit level_on[NPE];
        int comp_t[NPE];

        zero = (p == 0 || q == 0 || s == 0 || np == 0);
        pq = p * q;
        pass = 0; xf_pass = 0; xf_total = 0; ld_cycles = 0; starts = 0; dones = 0;
        start_t = 0; first_xf_t = 0; lat_max = 0; stall2 = 0; m_addr = 0;
        first_wr_seen = 0; prev_wr = 0; prev_xfer = 0; last_prev = 0; prev_gnt = '0;
        for (int i = 0; i < NPE; i++) begin level_on[i] = 0; comp_t[i] = -1; end

        t = 0;
        while (!cfg_ready && t < 50) begin @(negedge clk); t++; end
        check("cfg_ready_idle", cfg_ready, 1);
        cfg_P = 5'(p); cfg_Q = 3'(q); cfg_S = 4'(s); cfg_passes = 4'(np);
        drain_req = mask;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("pe_load_after_accept", pe_load, zero ? 0 : 4'hF);
        check("busy_after_accept", busy, 1);
        check("cfg_ready_after_accept", cfg_ready, 0);
        check("err_after_accept", err, 0);
        check("pass_idx_after_accept", pass_idx, 0);
        check("gb_addr_after_accept", gb_addr, 0);
        if (zero) begin
            check("done_zero_cfg", done, 1);
            @(negedge clk);
            check("zero_cfg_idle_ready", cfg_ready, 1);
            check("zero_cfg_no_load", pe_load, 0);
            check("zero_cfg_done_once", done, 0);
            return;
        end

        fin = 0; t = 0; timed_out = 0;
        while (!fin) begin
            if (t >= 20000) begin timed_out = 1; break; end
            if (rst_at > 0 && xf_total == rst_at) begin
                do_reset();
                return;
            end
            check("gnt_onehot0", $onehot0(drain_gnt), 1);
            check("wr_en_is_or_gnt", gb_wr_en, |drain_gnt);
            if (pe_load != 0) check("no_grant_in_load", drain_gnt, 0);
            if (last_prev) check("no_grant_after_last", drain_gnt, 0);
            if (prev_wr && !prev_xfer) check("grant_held", drain_gnt, prev_gnt);
            if (pe_load == 4'hF) ld_cycles++;

            if (pe_start != 0) begin
                check("pe_start_all", pe_start, 4'hF);
                check("pass_idx_at_start", pass_idx, pass);
                check("load_len", ld_cycles, pq);
                ld_cycles = 0; starts++; start_t = t; xf_pass = 0;
                first_wr_seen = 0; lat_max = 0;
                for (int i = 0; i < NPE; i++) begin
                    e = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 8);
                    comp_t[i] = t + e;
                    if (!(kill3 && i == 3) && e > lat_max) lat_max = e;
                end
            end
            if (gb_wr_en && !first_wr_seen) begin
                check("first_grant_latency", t - start_t, lat_max + 3);
                first_wr_seen = 1;
            end
            if (gb_wr_en) check("gb_addr", gb_addr, m_addr % (1 << AW));

            if (done) begin
                dones++;
`ifdef PE_SCHED_TIMEOUT_EN
                if (kill3) check("watchdog_latency", t - start_t, 4 * pq * s + 16);
                check("err_at_done", err, kill3 ? 1 : 0);
`else
                check("err_at_done", err, 0);
`endif
                if (!kill3) begin
                    check("passes_done", pass, np);
                    check("xfers_total", xf_total, np * p * NPE);
                    check("starts_total", starts, np);
                end
                fin = 1;
            end
`ifndef PE_SCHED_TIMEOUT_EN
            if (kill3 && starts > 0 && t - start_t == 200) begin
                check("hung_busy", busy, 1);
                check("hung_err", err, 0);
                check("hung_no_done", dones, 0);
                do_reset();
                return;
            end
`endif

            // drive inputs for this cycle
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 3) != 0);
                default: begin
                    rdy = 1'b1;
                    if (drain_gnt == 4'b0100 && stall2 < 3) begin rdy = 1'b0; stall2++; end
                end
            endcase
            gb_wr_ready = rdy;
            for (int i = 0; i < NPE; i++) begin
                bit v;
                if (pe_load == 4'hF) level_on[i] = 0;
                v = level_on[i];
                if (t == comp_t[i] && !(kill3 && i == 3)) begin
                    v = 1'b1;
                    if (!pulse) level_on[i] = 1;
                end
                if (pe_load == 4'hF) v = 1'($urandom_range(0, 1));
                pe_complete[i] = v;
            end
            cfg_valid = fin ? 1'b0 : 1'($urandom_range(0, 1));
            cfg_P = 5'($urandom); cfg_Q = 3'($urandom); cfg_S = 4'($urandom); cfg_passes = 4'($urandom);

            last_prev = 0;
            if (gb_wr_en && rdy) begin
                e = next_pe(mask, m_ptr);
                check("grant_pe", drain_gnt, 32'(1) << e);
                m_ptr = (e + 1) % NPE;
                m_addr++; xf_pass++; xf_total++;
                if (xf_pass == 1) first_xf_t = t;
                if (xf_pass == p * NPE) begin
                    if (rmode == 0) check("burst_len", t - first_xf_t + 1, p * NPE);
                    pass++;
                    last_prev = 1;
                end
            end
            prev_wr = gb_wr_en; prev_xfer = gb_wr_en && rdy; prev_gnt = drain_gnt;
            @(negedge clk);
            t++;
        end
        if (timed_out) begin
            check("run_timeout", t, 0);
            do_reset();
            return;
        end
        pe_complete = '0;
        check("done_one_cycle", done, 0);
        check("idle_not_busy", busy, 0);
        check("idle_cfg_ready", cfg_ready, 1);
`ifdef PE_SCHED_TIMEOUT_EN
        check("err_sticky", err, kill3 ? 1 : 0);
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outs_zero", all_outs(), 0);
        rstn = 1'b1;
        @(negedge clk);
        check("cfg_ready_first_edge", cfg_ready, 1);
        m_ptr = 0;

        fixed_lat = 5;
        run_cfg(2, 3, 1, 1, 4'hF, 0, 1'b1, 1'b0, 0);
        run_cfg(1, 1, 1, 1, 4'hF, 0, 1'b0, 1'b0, 0);
        fixed_lat = 0;
        run_cfg(2, 2, 1, 1, 4'hF, 2, 1'b1, 1'b0, 0);
        run_cfg(4, 2, 1, 3, 4'($urandom_range(1, 15)), 1, 1'b0, 1'b0, 0);
        run_cfg(0, 3, 1, 1, 4'hF, 0, 1'b1, 1'b0, 0);
        run_cfg(2, 0, 1, 1, 4'hF, 0, 1'b1, 1'b0, 0);
        run_cfg(2, 3, 0, 1, 4'hF, 0, 1'b1, 1'b0, 0);
        run_cfg(2, 3, 1, 0, 4'hF, 0, 1'b1, 1'b0, 0);
        run_cfg(6, 1, 1, 1, 4'hF, 1, 1'b1, 1'b0, 5);
        run_cfg(3, 2, 2, 2, 4'b1010, 1, 1'b1, 1'b0, 0);
        run_cfg(1, 1, 1, 1, 4'hF, 0, 1'b1, 1'b1, 0);
        run_cfg(2, 1, 1, 1, 4'hF, 0, 1'b1, 1'b0, 0);
        run_cfg(31, 7, 1, 1, 4'hF, 0, 1'b1, 1'b0, 0);
        run_cfg(31, 1, 1, 9, 4'hF, 0, 1'b0, 1'b0, 0);
        for (int r = 0; r < 12; r++)
            run_cfg($urandom_range(1, 5), $urandom_range(1, 7), $urandom_range(1, 15),
                    $urandom_range(1, 3), 4'($urandom_range(1, 15)), $urandom_range(0, 1),
                    1'($urandom_range(0, 1)), 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pe_array_sched.md
PE_ARRAY_SCHED -- requirements
Module: pe_array_sched

Interface
REQ-001 Parameter NUM_PE, default 4, number of PEs sequenced; this block is verified only at 4.
REQ-002 Parameter ADDR_W, default 10, global-buffer write address width.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rstn  in  1  reset, asynchronous, active-low.
REQ-005 cfg_valid/cfg_ready  in/out  1/1  configuration handshake.
REQ-006 cfg_P, cfg_Q, cfg_S, cfg_passes  in  5/3/4/4  tile geometry and pass count.
REQ-007 pe_load  out  NUM_PE  load phase to each PE.
REQ-008 pe_start  out  NUM_PE  one-cycle start pulse to each PE.
REQ-009 pe_complete  in  NUM_PE  per-PE completion; may be a pulse or a level.
REQ-010 drain_req/drain_gnt  in/out  NUM_PE each  psum drain request and one-hot grant.
REQ-011 gb_wr_en/gb_wr_ready  out/in  1/1  global-buffer write handshake.
REQ-012 gb_addr  out  ADDR_W  write address.
REQ-013 busy, done, err, pass_idx  out  1/1/1/4  status.

Function
REQ-014 FSM states: IDLE, LOAD, RUN, DRAIN, DONE. All outputs are registered.
REQ-015 IDLE: cfg_ready=1. cfg_valid&cfg_ready latches the config, clears pass_idx, and enters LOAD; pe_load rises 1 cycle after acceptance.
REQ-016 Any latched field equal to 0 (P, Q, S or passes): go directly to DONE with no PE activity.
REQ-017 cfg_valid outside IDLE is ignored; cfg_ready=0 outside IDLE.
REQ-018 LOAD: pe_load all ones for exactly P*Q cycles (8-bit counter), then RUN; sticky complete captures are cleared on LOAD entry.
REQ-019 RUN: pe_start all ones on the first RUN cycle only. Each pe_complete bit is captured sticky. When all NUM_PE captures are set, go to DRAIN on the next cycle.
REQ-020 DRAIN: round-robin arbitration over drain_req. drain_gnt is one-hot or zero. gb_wr_en = |drain_gnt.
REQ-021 A transfer occurs when gb_wr_en&gb_wr_ready.
  - Grant is held unchanged while gb_wr_ready=0.
  - After a transfer from PE i, priority starts at (i+1) mod NUM_PE.
  - The pointer resets to 0.
REQ-022 gb_addr increments by 1 per transfer and wraps from 2^ADDR_W-1 to 0. It is cleared only on config acceptance.
REQ-023 DRAIN ends after P*NUM_PE transfers.
  - If pass_idx == passes-1: go to DONE.
  - Else: pass_idx+1 and go to LOAD.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE. busy=1 in every state except IDLE.
REQ-025 pe_complete seen in LOAD, DRAIN or IDLE has no effect.
REQ-026 drain_req seen outside DRAIN is not granted.
REQ-027 If the last required transfer and a new drain_req arrive in the same cycle, the new request is not granted.

Reset
REQ-028 rstn low asynchronously forces the following, regardless of the current state (including mid-pass):
  - state IDLE;
  - counters, pointer, captures and gb_addr to 0;
  - all outputs 0, including cfg_ready.
REQ-029 cfg_ready rises on the first clk edge after rstn deasserts.

Configuration
REQ-030 Macro PE_SCHED_TIMEOUT_EN.
  - When defined: a 12-bit RUN watchdog counts from RUN entry. If all completes are not captured within 4*P*Q*S+16 cycles, err is set sticky until reset or next config acceptance, and the FSM goes to DONE.
  - When undefined: no watchdog exists, err is tied 0, and RUN waits indefinitely.

Verification
REQ-031 P=2,Q=3,S=1,passes=1; all PEs complete 5 cycles after start; gb_wr_ready=1 -> pe_load high 6 cycles, single pe_start pulse, 8 writes at gb_addr 0..7, done pulse, cfg_ready=1.
REQ-032 All drain_req=1, gb_wr_ready=1, P=1 -> grants in order PE0,PE1,PE2,PE3, one per cycle.
REQ-033 gb_wr_ready=0 for 3 cycles while PE2 is granted -> drain_gnt stays 0100 and gb_addr is unchanged until ready.
REQ-034 passes=3, P=4 -> pass_idx steps 0,1,2; 48 transfers total; one done pulse only.
REQ-035 rstn pulsed low mid-DRAIN -> all outputs 0 immediately; cfg_ready=1 one edge after release; a new config runs cleanly.
REQ-036 PE_SCHED_TIMEOUT_EN defined, PE3 never completes, P=Q=S=1 -> err=1 and done after 20 RUN cycles; undefined -> busy stays 1 and err stays 0.
